// File: rtl/ccff_bitstream_loader.sv
// Serial configuration-chain loader: feeds bitstream words LSB-first onto ccff_head with a chain clock-enable.
// Define CCFF_READBACK_EN to also collect the old chain contents arriving on ccff_tail into tail_data words.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] tail_data,
  output logic              tail_valid
);

  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX_C  = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic              ready_q, ready_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Outputs are derived from the next state so they register in step with state_q.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    bits_left_d = bits_left_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bits_left_d = CHAIN_LEN_C;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (word_valid) begin
          shreg_d   = word_data;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d     = shreg_q >> 1;
        bit_idx_d   = bit_idx_q + 1'b1;
        bits_left_d = bits_left_q - 1'b1;
        // Chain full wins over word exhausted: leftover word bits are dropped.
        if (bits_left_q == ONE_C)          state_d = S_DONE;
        else if (bit_idx_q == LAST_IDX_C)  state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d  = (state_d == S_FETCH);
    clk_en_d = (state_d == S_SHIFT);
    head_d   = (state_d == S_SHIFT) ? shreg_d[0] : 1'b0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      bits_left_q <= '0;
      ready_q     <= 1'b0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      bits_left_q <= bits_left_d;
      ready_q     <= ready_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign word_ready  = ready_q;
  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] col_q, col_d, col_nxt;
  logic [WORD_W-1:0] tail_data_q, tail_data_d;
  logic              tail_valid_q, tail_valid_d;

  // Tail bit lands at the same word position as the head bit being shifted in this cycle.
  always_comb begin
    col_d        = col_q;
    col_nxt      = col_q | (WORD_W'(ccff_tail) << bit_idx_q);
    tail_data_d  = tail_data_q;
    tail_valid_d = 1'b0;
    if (state_q == S_IDLE && start) begin
      col_d = '0;
    end else if (state_q == S_SHIFT) begin
      col_d = col_nxt;
      if (bits_left_q == ONE_C || bit_idx_q == LAST_IDX_C) begin
        tail_data_d  = col_nxt;
        tail_valid_d = 1'b1;
        col_d        = '0;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      col_q        <= '0;
      tail_data_q  <= '0;
      tail_valid_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      tail_data_q  <= tail_data_d;
      tail_valid_q <= tail_valid_d;
    end
  end

  assign tail_data  = tail_data_q;
  assign tail_valid = tail_valid_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign tail_data   = '0;
  assign tail_valid  = 1'b0;
`endif

endmodule
